// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw button level in, conditioned level,
// edge pulses and press count out.
interface button_debouncer_if #(
   parameter int COUNT_WIDTH = 8
);
   logic                   IN;
   logic                   OUT;
   logic                   RISE;
   logic                   FALL;
   logic [COUNT_WIDTH-1:0] PRESS_COUNT;

   modport master (output IN, input OUT, RISE, FALL, PRESS_COUNT);
   modport slave  (input IN, output OUT, RISE, FALL, PRESS_COUNT);
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus a four-state debounce FSM producing a clean level,
// one-cycle press/release pulses and a wrapping press counter.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int COUNT_WIDTH     = 8
) (
   input logic                CLK,
   input logic                RESET,
   button_debouncer_if.slave  bus
);
   localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_CHECK,
      PRESSED,
      RELEASE_CHECK
   } state_t;

   state_t                 state;
   logic                   sync1;
   logic                   sync2;
   logic [CW-1:0]          cnt;
   logic                   out_q;
   logic                   rise_q;
   logic                   fall_q;
   logic [COUNT_WIDTH-1:0] press_count;

   // Outputs are set on the transition edges, so they stay aligned with the state.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync1       <= 1'b0;
         sync2       <= 1'b0;
         state       <= RELEASED;
         cnt         <= '0;
         out_q       <= 1'b0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         press_count <= '0;
      end else begin
         sync1  <= bus.IN;
         sync2  <= sync1;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         case (state)
            RELEASED: begin
               if (sync2) begin
                  state <= PRESS_CHECK;
                  cnt   <= '0;
               end
            end
            PRESS_CHECK: begin
               if (!sync2) begin
                  state <= RELEASED;
               end else if (cnt == LAST) begin
                  state       <= PRESSED;
                  out_q       <= 1'b1;
                  rise_q      <= 1'b1;
                  press_count <= press_count + COUNT_WIDTH'(1);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            PRESSED: begin
               if (!sync2) begin
                  state <= RELEASE_CHECK;
                  cnt   <= '0;
               end
            end
            RELEASE_CHECK: begin
               if (sync2) begin
                  state <= PRESSED;
               end else if (cnt == LAST) begin
                  state  <= RELEASED;
                  out_q  <= 1'b0;
                  fall_q <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= RELEASED;
         endcase
      end
   end

   assign bus.OUT         = out_q;
   assign bus.RISE        = rise_q;
   assign bus.FALL        = fall_q;
   assign bus.PRESS_COUNT = press_count;
endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench: stimulus queues expected RISE/FALL pulses (kind, count, cycle);
// a negedge monitor pops and compares each pulse the debouncer emits.
module tb_button_debouncer;
   localparam int D   = 4;
   localparam int LAT = D + 3;

   logic CLK;
   logic RESET;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   exp_cnt = 0;
   int   rise_seen = 0;
   int   fall_seen = 0;

   typedef struct {
      bit is_rise;
      int cnt;
      int cyc;
   } ev_t;
   ev_t q[$];

   button_debouncer_if #(.COUNT_WIDTH(8)) bus ();

   button_debouncer #(.DEBOUNCE_CYCLES(D), .COUNT_WIDTH(8)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Ends one time unit after the n-th following rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // The next edge samples the new IN level; the pulse follows LAT edges later.
   task automatic press_expect();
      exp_cnt = (exp_cnt + 1) % 256;
      q.push_back('{is_rise: 1'b1, cnt: exp_cnt, cyc: cyc + LAT});
   endtask

   task automatic release_expect();
      q.push_back('{is_rise: 1'b0, cnt: exp_cnt, cyc: cyc + LAT});
   endtask

   task automatic pulse_reset();
      #1 RESET = 1'b1;
      #1;
      chk("reset_out", int'(bus.OUT), 0);
      chk("reset_rise", int'(bus.RISE), 0);
      chk("reset_fall", int'(bus.FALL), 0);
      chk("reset_count", int'(bus.PRESS_COUNT), 0);
      q.delete();
      exp_cnt = 0;
      #1 RESET = 1'b0;
   endtask

   always @(negedge CLK) begin : monitor
      ev_t e;
      if (!RESET && (bus.RISE || bus.FALL)) begin
         if (bus.RISE) rise_seen++;
         if (bus.FALL) fall_seen++;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: rise=%0d fall=%0d count=%0d at cycle %0d, no pulse required",
                     bus.RISE, bus.FALL, bus.PRESS_COUNT, cyc);
         end else begin
            e = q.pop_front();
            chk("pulse_kind_rise", int'(bus.RISE), int'(e.is_rise));
            chk("pulse_exclusive", int'(bus.RISE && bus.FALL), 0);
            chk("pulse_count", int'(bus.PRESS_COUNT), e.cnt);
            chk("pulse_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RESET  = 1'b1;
      bus.IN = 1'b0;
      tick(3);
      chk("init_out", int'(bus.OUT), 0);
      chk("init_rise", int'(bus.RISE), 0);
      chk("init_fall", int'(bus.FALL), 0);
      chk("init_count", int'(bus.PRESS_COUNT), 0);
      RESET = 1'b0;
      tick(2);

      // Clean press: OUT rises on the 7th edge.
      bus.IN = 1'b1;
      press_expect();
      tick(LAT - 1);
      chk("press_out_early", int'(bus.OUT), 0);
      tick(1);
      chk("press_out", int'(bus.OUT), 1);
      chk("press_count", int'(bus.PRESS_COUNT), 1);
      tick(13);

      // Clean release.
      bus.IN = 1'b0;
      release_expect();
      tick(LAT - 1);
      chk("release_out_early", int'(bus.OUT), 1);
      tick(1);
      chk("release_out", int'(bus.OUT), 0);
      chk("release_count", int'(bus.PRESS_COUNT), 1);
      tick(13);

      // Bounce with 3-cycle high segments: nothing accepted.
      bus.IN = 1'b1; tick(3);
      bus.IN = 1'b0; tick(3);
      bus.IN = 1'b1; tick(3);
      bus.IN = 1'b0; tick(12);
      chk("bounce_out", int'(bus.OUT), 0);
      chk("bounce_count", int'(bus.PRESS_COUNT), 1);

      // Press, then a 2-cycle high glitch during RELEASE_CHECK delays FALL.
      bus.IN = 1'b1;
      press_expect();
      tick(10);
      bus.IN = 1'b0; tick(2);
      bus.IN = 1'b1; tick(2);
      bus.IN = 1'b0;
      release_expect();
      tick(LAT - 1);
      chk("glitch_out_held", int'(bus.OUT), 1);
      tick(1);
      chk("glitch_out", int'(bus.OUT), 0);
      chk("glitch_count", int'(bus.PRESS_COUNT), 2);
      tick(6);

      // Wrap test from a cleared counter.
      pulse_reset();
      tick(2);
      begin
         int r0, f0;
         r0 = rise_seen;
         f0 = fall_seen;
         for (int i = 0; i < 256; i++) begin
            bus.IN = 1'b1;
            press_expect();
            tick(LAT + 1);
            if (i == 254) chk("wrap_count_255", int'(bus.PRESS_COUNT), 255);
            if (i == 255) chk("wrap_count_0", int'(bus.PRESS_COUNT), 0);
            bus.IN = 1'b0;
            release_expect();
            tick(LAT + 1);
         end
         chk("wrap_rise_pulses", rise_seen - r0, 256);
         chk("wrap_fall_pulses", fall_seen - f0, 256);
      end

      // Reset two cycles into PRESS_CHECK, IN held high: fresh press afterwards.
      bus.IN = 1'b1;
      tick(5);
      pulse_reset();
      press_expect();
      tick(LAT + 1);
      chk("post_reset_out", int'(bus.OUT), 1);
      chk("post_reset_count", int'(bus.PRESS_COUNT), 1);

      // Reset while PRESSED.
      tick(3);
      pulse_reset();
      press_expect();
      tick(LAT + 1);
      chk("pressed_reset_count", int'(bus.PRESS_COUNT), 1);

      // Reset during RELEASE_CHECK: the pending FALL never appears.
      bus.IN = 1'b0;
      tick(4);
      pulse_reset();
      tick(12);
      chk("no_fall_out", int'(bus.OUT), 0);
      chk("no_fall_count", int'(bus.PRESS_COUNT), 0);

      tick(2);
      chk("pending_pulses", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
